// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, data widths and arbiter FSM states.
// ctrl_legal backs the optional ALU_ARB_OPCHECK_EN illegal-opcode flag.
package alu_pkg;

  localparam int ALU_CTRL_W = 4;
  localparam int ALU_DATA_W = 32;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND   = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR    = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD   = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR   = 4'b0011;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB   = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT   = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADDB  = 4'b1000;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADDBS = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } arb_state_t;

  function automatic logic ctrl_legal(
    input logic [ALU_CTRL_W-1:0] c
  );
    return c inside {ALU_AND, ALU_OR, ALU_ADD,
                     ALU_XOR, ALU_SUB, ALU_SLT,
                     ALU_ADDB, ALU_ADDBS};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit
// strictly after 'last', wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int j;

  // Walk from the farthest offset down so the nearest one wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = int'(last) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external 32-bit ALU among NUM_REQ requesters, one op in flight.
// Define ALU_ARB_OPCHECK_EN to flag illegal ctrl codes on rsp_err.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [ALU_DATA_W*NUM_REQ-1:0] req_srcA,
  input  logic [ALU_DATA_W*NUM_REQ-1:0] req_srcB,
  input  logic [ALU_CTRL_W*NUM_REQ-1:0] req_ctrl,
  input  logic [TAG_W*NUM_REQ-1:0]      req_tag,
  output logic [ALU_DATA_W-1:0]         alu_srcA,
  output logic [ALU_DATA_W-1:0]         alu_srcB,
  output logic [ALU_CTRL_W-1:0]         alu_ctrl,
  input  logic [ALU_DATA_W-1:0]         alu_result,
  input  logic                          alu_zero,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [TAG_W-1:0]              rsp_tag,
  output logic [ALU_DATA_W-1:0]         rsp_result,
  output logic                          rsp_zero,
  output logic                          rsp_err
);

  arb_state_t             state;
  logic [ID_W-1:0]        last_grant;
  logic [ID_W-1:0]        gidx;
  logic [ID_W-1:0]        op_id;
  logic [TAG_W-1:0]       op_tag;
  logic [NUM_REQ-1:0]     grant;
  logic                   gany;
  logic                   accept_ok;
  logic                   take;
  logic [ALU_CTRL_W-1:0]  sel_ctrl;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_rr (
    .req   (req_valid),
    .last  (last_grant),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  // A new op is taken in IDLE, or in RESP as the response drains.
  assign accept_ok = rst_n &&
                     (state == ST_IDLE ||
                      (state == ST_RESP && rsp_ready));
  assign req_ready = accept_ok ? grant : '0;
  assign take      = accept_ok && gany;
  assign sel_ctrl  = req_ctrl[ALU_CTRL_W*gidx +: ALU_CTRL_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_srcA   <= '0;
      alu_srcB   <= '0;
      alu_ctrl   <= '0;
      op_id      <= '0;
      op_tag     <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (take) begin
      alu_srcA   <= req_srcA[ALU_DATA_W*gidx +: ALU_DATA_W];
      alu_srcB   <= req_srcB[ALU_DATA_W*gidx +: ALU_DATA_W];
      alu_ctrl   <= sel_ctrl;
      op_id      <= gidx;
      op_tag     <= req_tag[TAG_W*gidx +: TAG_W];
      last_grant <= gidx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_tag    <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (take) state <= ST_EXEC;
        end
        ST_EXEC: begin
          rsp_valid  <= 1'b1;
          rsp_id     <= op_id;
          rsp_tag    <= op_tag;
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= take ? ST_EXEC : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  logic op_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_err  <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      if (take) op_err <= !ctrl_legal(sel_ctrl);
      if (state == ST_EXEC) rsp_err <= op_err;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus a randomized
// run against a scoreboard model, with a behavioural ALU on alu_*.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int N  = 4;
  localparam int TW = 4;
`ifdef ALU_ARB_OPCHECK_EN
  localparam bit OPCHECK = 1'b1;
`else
  localparam bit OPCHECK = 1'b0;
`endif

  typedef struct {
    logic [1:0]    id;
    logic [TW-1:0] tag;
    logic [31:0]   res;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [31:0]     a_in [N];
  logic [31:0]     b_in [N];
  logic [3:0]      c_in [N];
  logic [TW-1:0]   t_in [N];
  logic [32*N-1:0] req_srcA, req_srcB;
  logic [4*N-1:0]  req_ctrl;
  logic [TW*N-1:0] req_tag;
  logic [31:0]     alu_srcA, alu_srcB, alu_result;
  logic [3:0]      alu_ctrl;
  logic            alu_zero;
  logic            rsp_valid, rsp_ready, rsp_zero, rsp_err;
  logic [1:0]      rsp_id;
  logic [TW-1:0]   rsp_tag;
  logic [31:0]     rsp_result;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] alu_fn(
    input logic [31:0] a, input logic [31:0] b, input logic [3:0] c
  );
    logic [31:0] r;
    logic [8:0]  s;
    r = '0;
    case (c)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_ADD: r = a + b;
      ALU_XOR: r = a ^ b;
      ALU_SUB: r = a - b;
      ALU_SLT: r = {31'd0, $signed(a) < $signed(b)};
      ALU_ADDB, ALU_ADDBS: begin
        for (int i = 0; i < 4; i++) begin
          s = {1'b0, a[8*i +: 8]} + {1'b0, b[8*i +: 8]};
          r[8*i +: 8] = (c == ALU_ADDBS && s[8]) ? 8'hFF : s[7:0];
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic exp_err(input logic [3:0] c);
    return OPCHECK &&
      !(c inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9});
  endfunction

  always_comb begin
    alu_result = alu_fn(alu_srcA, alu_srcB, alu_ctrl);
    alu_zero   = (alu_result == 32'd0);
  end

  always_comb begin
    req_srcA = '0;
    req_srcB = '0;
    req_ctrl = '0;
    req_tag  = '0;
    for (int i = 0; i < N; i++) begin
      req_srcA[32*i +: 32] = a_in[i];
      req_srcB[32*i +: 32] = b_in[i];
      req_ctrl[4*i +: 4]   = c_in[i];
      req_tag[TW*i +: TW]  = t_in[i];
    end
  end

  alu_share_arbiter #(.NUM_REQ(N), .TAG_W(TW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_srcA   (req_srcA),
    .req_srcB   (req_srcB),
    .req_ctrl   (req_ctrl),
    .req_tag    (req_tag),
    .alu_srcA   (alu_srcA),
    .alu_srcB   (alu_srcB),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_tag    (rsp_tag),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_op(
    input int idx, input logic [31:0] a, input logic [31:0] b,
    input logic [3:0] c, input logic [TW-1:0] t,
    output logic [31:0] res, output logic z, output logic e,
    output logic [1:0] id, output logic [TW-1:0] tg, output int lat
  );
    int n;
    res = '0; z = 1'b0; e = 1'b0; id = '0; tg = '0; lat = -1;
    a_in[idx] = a; b_in[idx] = b; c_in[idx] = c; t_in[idx] = t;
    req_valid[idx] = 1'b1;
    rsp_ready = 1'b0;
    #1;
    n = 0;
    while (!req_ready[idx] && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!req_ready[idx]) begin
      req_valid[idx] = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid[idx] = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk); n++;
    end
    if (rsp_valid) begin
      lat = n; res = rsp_result; z = rsp_zero;
      e = rsp_err; id = rsp_id; tg = rsp_tag;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    req_valid = '1;
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (req_ready !== 4'b0) begin
      errors++; $display("FAIL reset_ready got %b want 0000", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_tag !== '0) begin
      errors++;
      $display("FAIL reset_rsp got v=%b id=%0d tag=%0d want 0",
               rsp_valid, rsp_id, rsp_tag);
    end
    checks++;
    if (rsp_result !== 32'd0 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_data got res=%h z=%b e=%b want 0",
               rsp_result, rsp_zero, rsp_err);
    end
    checks++;
    if (alu_srcA !== '0 || alu_srcB !== '0 || alu_ctrl !== '0) begin
      errors++;
      $display("FAIL reset_alu got %h %h %h want 0",
               alu_srcA, alu_srcB, alu_ctrl);
    end
    req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [31:0] r; logic z, e; logic [1:0] id; logic [TW-1:0] tg; int lat;
    do_reset();
    run_op(0, 32'd5, 32'd7, ALU_ADD, 4'd3, r, z, e, id, tg, lat);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL single_latency got %0d want 2", lat);
    end
    checks++;
    if (r !== 32'd12 || z !== 1'b0) begin
      errors++; $display("FAIL single_result got %0d z=%b want 12 z=0", r, z);
    end
    checks++;
    if (id !== 2'd0 || tg !== 4'd3) begin
      errors++; $display("FAIL single_id got id=%0d tag=%0d want 0 3", id, tg);
    end
  endtask

  task automatic test_round_robin();
    int   gseq[$];
    int   rtimes[$];
    exp_t q[$];
    exp_t x;
    int   g;
    do_reset();
    for (int i = 0; i < N; i++) begin
      a_in[i] = $urandom; b_in[i] = $urandom;
      c_in[i] = ALU_ADD;  t_in[i] = TW'(i + 8);
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      #1;
      if (rsp_valid) begin
        rtimes.push_back(c);
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rr_spurious got rsp id=%0d want none", rsp_id);
        end else begin
          x = q.pop_front();
          if (rsp_id !== x.id || rsp_tag !== x.tag || rsp_result !== x.res) begin
            errors++;
            $display("FAIL rr_rsp got id=%0d tag=%0d res=%h want %0d %0d %h",
                     rsp_id, rsp_tag, rsp_result, x.id, x.tag, x.res);
          end
        end
      end
      if (req_ready != 0) begin
        g = $clog2(int'(req_ready));
        gseq.push_back(g);
        q.push_back('{id: 2'(g), tag: t_in[g],
                      res: alu_fn(a_in[g], b_in[g], c_in[g]), err: 1'b0});
      end
      @(negedge clk);
      if (gseq.size() > 0 && req_ready == 0) begin
        g = gseq[gseq.size()-1];
        a_in[g] = $urandom; b_in[g] = $urandom;
      end
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    checks++;
    if (gseq.size() < 6) begin
      errors++; $display("FAIL rr_count got %0d grants want >=6", gseq.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        if (gseq[k] != k % N) begin
          errors++;
          $display("FAIL rr_order grant %0d got %0d want %0d", k, gseq[k], k % N);
          break;
        end
      end
    end
    checks++;
    if (rtimes.size() < 5) begin
      errors++; $display("FAIL rr_rate got %0d responses want >=5", rtimes.size());
    end else begin
      for (int k = 1; k < rtimes.size(); k++) begin
        if (rtimes[k] - rtimes[k-1] != 2) begin
          errors++;
          $display("FAIL rr_spacing got %0d cycles want 2",
                   rtimes[k] - rtimes[k-1]);
          break;
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] sr; logic [1:0] sid; logic [TW-1:0] st; int n;
    do_reset();
    a_in[1] = 32'h0F0F_00FF; b_in[1] = 32'h00FF_0FF0;
    c_in[1] = ALU_AND; t_in[1] = 4'd5;
    a_in[2] = 32'd1; b_in[2] = 32'd2; c_in[2] = ALU_OR; t_in[2] = 4'd6;
    req_valid[1] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[1] && n < 20) begin @(negedge clk); #1; n++; end
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL stall_grant1 got %b want 0010", req_ready);
    end
    @(negedge clk);
    req_valid[1] = 1'b0;
    req_valid[2] = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0) begin
      errors++; $display("FAIL stall_exec_ready got %b want 0000", req_ready);
    end
    @(negedge clk);
    sr = rsp_result; sid = rsp_id; st = rsp_tag;
    checks++;
    if (rsp_valid !== 1'b1 || sid !== 2'd1 || sr !== 32'h000F_00F0) begin
      errors++;
      $display("FAIL stall_rsp got v=%b id=%0d res=%h want 1 1 000f00f0",
               rsp_valid, sid, sr);
    end
    repeat (5) begin
      #1;
      checks++;
      if (req_ready !== 4'b0 || rsp_valid !== 1'b1 || rsp_result !== sr ||
          rsp_id !== sid || rsp_tag !== st) begin
        errors++;
        $display("FAIL stall_hold got rdy=%b v=%b res=%h want 0000 1 %h",
                 req_ready, rsp_valid, rsp_result, sr);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL stall_release got %b want 0100", req_ready);
    end
    @(negedge clk);
    req_valid[2] = 1'b0;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL stall_drop got v=%b want 0", rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 32'd3) begin
      errors++;
      $display("FAIL stall_next got v=%b id=%0d res=%0d want 1 2 3",
               rsp_valid, rsp_id, rsp_result);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_ops();
    logic [31:0] r; logic z, e; logic [1:0] id; logic [TW-1:0] tg; int lat;
    run_op(3, 32'd9, 32'd9, ALU_SUB, 4'd1, r, z, e, id, tg, lat);
    checks++;
    if (r !== 32'd0 || z !== 1'b1 || id !== 2'd3) begin
      errors++; $display("FAIL op_sub got %h z=%b id=%0d want 0 1 3", r, z, id);
    end
    run_op(2, 32'hFFFF_FFFF, 32'd1, ALU_SLT, 4'd2, r, z, e, id, tg, lat);
    checks++;
    if (r !== 32'd1 || z !== 1'b0 || id !== 2'd2) begin
      errors++; $display("FAIL op_slt got %h z=%b id=%0d want 1 0 2", r, z, id);
    end
    run_op(1, 32'hF0F0_F0F0, 32'h2020_2020, ALU_ADDBS, 4'd4, r, z, e, id, tg, lat);
    checks++;
    if (r !== 32'hFFFF_FFFF || tg !== 4'd4) begin
      errors++; $display("FAIL op_addbs got %h tag=%0d want ffffffff 4", r, tg);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    a_in[0] = 32'hDEAD_0001; b_in[0] = 32'd1; c_in[0] = ALU_ADD; t_in[0] = 4'd7;
    req_valid[0] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[0] && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    req_valid[0] = 1'b0;
    checks++;
    if (alu_srcA !== 32'hDEAD_0001) begin
      errors++; $display("FAIL mid_exec_alu got %h want dead0001", alu_srcA);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || alu_srcA !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset got v=%b alu=%h want 0 0", rsp_valid, alu_srcA);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("FAIL mid_noreplay got v=%b want 0", rsp_valid);
      end
    end
    req_valid[0] = 1'b1;
    req_valid[2] = 1'b1;
    c_in[2] = ALU_XOR;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL mid_first got %b want 0001", req_ready);
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_tag !== 4'd7) begin
      errors++;
      $display("FAIL mid_rsp0 got v=%b id=%0d tag=%0d want 1 0 7",
               rsp_valid, rsp_id, rsp_tag);
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL mid_second got %b want 0100", req_ready);
    end
    @(negedge clk);
    req_valid[2] = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin
      errors++;
      $display("FAIL mid_rsp2 got v=%b id=%0d want 1 2", rsp_valid, rsp_id);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_illegal();
    logic [31:0] r; logic z, e; logic [1:0] id; logic [TW-1:0] tg; int lat;
    run_op(1, 32'd123, 32'd456, 4'b1111, 4'd9, r, z, e, id, tg, lat);
    checks++;
    if (e !== OPCHECK || r !== 32'd0 || z !== 1'b1) begin
      errors++;
      $display("FAIL illegal_op got err=%b res=%h z=%b want %b 0 1",
               e, r, z, OPCHECK);
    end
    run_op(0, 32'd1, 32'd2, ALU_ADDB, 4'd2, r, z, e, id, tg, lat);
    checks++;
    if (e !== 1'b0 || r !== 32'd3) begin
      errors++; $display("FAIL legal_op got err=%b res=%h want 0 3", e, r);
    end
  endtask

  task automatic test_random();
    int   model_last;
    bit   outstanding;
    int   age;
    bit   allowed, found;
    int   g, j;
    exp_t x;
    logic [N-1:0] just_acc;
    logic [N-1:0] want_ready;
    do_reset();
    model_last = N - 1;
    outstanding = 0;
    age = 0;
    just_acc = '0;
    x = '{id: '0, tag: '0, res: '0, err: 1'b0};
    for (int c = 0; c < 400; c++) begin
      if (outstanding) age++;
      checks++;
      if (rsp_valid !== (outstanding && age >= 2)) begin
        errors++;
        $display("FAIL rand_valid cyc %0d got %b want %b",
                 c, rsp_valid, outstanding && age >= 2);
      end else if (rsp_valid) begin
        checks++;
        if (rsp_id !== x.id || rsp_tag !== x.tag || rsp_result !== x.res ||
            rsp_zero !== (x.res == 0) || rsp_err !== x.err) begin
          errors++;
          $display("FAIL rand_rsp cyc %0d got id=%0d tag=%0d res=%h e=%b want %0d %0d %h %b",
                   c, rsp_id, rsp_tag, rsp_result, rsp_err,
                   x.id, x.tag, x.res, x.err);
        end
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < N; i++) begin
        if (just_acc[i]) req_valid[i] = 1'b0;
        if (req_valid[i]) begin
          if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          a_in[i] = $urandom; b_in[i] = $urandom;
          c_in[i] = 4'($urandom_range(0, 15));
          t_in[i] = TW'($urandom);
        end
      end
      just_acc = '0;
      #1;
      allowed = !outstanding || (age >= 2 && rsp_ready);
      found = 0;
      g = 0;
      for (int k = 1; k <= N; k++) begin
        j = (model_last + k) % N;
        if (!found && req_valid[j]) begin
          g = j; found = 1;
        end
      end
      want_ready = (allowed && found) ? N'(1 << g) : '0;
      checks++;
      if (req_ready !== want_ready) begin
        errors++;
        $display("FAIL rand_grant cyc %0d got %b want %b", c, req_ready, want_ready);
      end
      if (outstanding && age >= 2 && rsp_ready) outstanding = 0;
      if (allowed && found) begin
        outstanding = 1;
        age = 0;
        x = '{id: 2'(g), tag: t_in[g],
              res: alu_fn(a_in[g], b_in[g], c_in[g]), err: exp_err(c_in[g])};
        model_last = g;
        just_acc[g] = 1'b1;
      end
      @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = 1'b0;
  endtask

  initial begin
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_in[i] = '0; b_in[i] = '0; c_in[i] = '0; t_in[i] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_ops();
    test_reset_mid();
    test_illegal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
